// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, exception codes, FSM states and
// the bit positions used inside Status and Cause.
package cp0_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam int ST_IE      = 0;
  localparam int ST_EXL     = 1;
  localparam int ST_IM_LSB  = 8;
  localparam int CA_EXC_LSB = 2;
  localparam int CA_IP_LSB  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAP  = 2'd1,
    RET   = 2'd2,
    DRAIN = 2'd3
  } cp0_state_e;

endpackage

// File: rtl/cp0_regs.sv
// Status/Cause/EPC storage with trap, eret and mtc0 update paths and the
// combinational mfc0 read mux.
module cp0_regs
  import cp0_pkg::*;
#(
  parameter int NIRQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq,
  input  logic            trap_we,
  input  logic [4:0]      trap_code,
  input  logic [31:0]     trap_pc,
  input  logic            eret_we,
  input  logic            mtc0_we,
  input  logic [4:0]      dreg,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            status_ie,
  output logic            status_exl,
  output logic [NIRQ-1:0] status_im,
  output logic [NIRQ-1:0] cause_ip,
  output logic [31:0]     epc
);

  logic [4:0] exc_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      status_ie  <= 1'b0;
      status_exl <= 1'b0;
      status_im  <= '0;
      cause_ip   <= '0;
      exc_code   <= '0;
      epc        <= '0;
    end else begin
      // IP mirrors the request lines; irq is assumed synchronous to clk.
      cause_ip <= irq;
      if (trap_we) begin
        exc_code   <= trap_code;
        status_exl <= 1'b1;
        // A nested trap keeps the EPC of the outermost one.
        if (!status_exl) epc <= trap_pc;
      end else if (eret_we) begin
        status_exl <= 1'b0;
      end else if (mtc0_we) begin
        case (dreg)
          CP0_STATUS: begin
            status_ie  <= wdata[ST_IE];
            status_exl <= wdata[ST_EXL];
            status_im  <= wdata[ST_IM_LSB +: NIRQ];
          end
          CP0_EPC: epc <= wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (dreg)
      CP0_STATUS: begin
        rdata[ST_IE]               = status_ie;
        rdata[ST_EXL]              = status_exl;
        rdata[ST_IM_LSB +: NIRQ]   = status_im;
      end
      CP0_CAUSE: begin
        rdata[CA_EXC_LSB +: 5]     = exc_code;
        rdata[CA_IP_LSB +: NIRQ]   = cause_ip;
      end
      CP0_EPC: rdata = epc;
      default: ;
    endcase
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: priority resolution of MEM-stage events,
// flush/redirect sequencing and a fixed drain window after each redirect.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0008,
  parameter int          DRAIN_CYCLES = 3,
  parameter int          NIRQ         = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  input  logic [31:0]     mem_pc,
  input  logic            mem_syscall,
  input  logic            mem_unknown,
  input  logic            mem_overflow,
  input  logic            mem_eret,
  input  logic            mem_cp0_we,
  input  logic [4:0]      mem_cp0_dreg,
  input  logic [31:0]     mem_cp0_wdata,
  input  logic            pipe_stall,
  input  logic [NIRQ-1:0] irq,
  output logic [31:0]     cp0_rdata,
  output logic            exc_kill,
  output logic            flush,
  output logic            redirect_valid,
  output logic [31:0]     redirect_pc,
  output cp0_state_e      dbg_state
);

  // redirect_valid is a one-cycle strobe with no ready: the fetch stage must
  // load redirect_pc in the cycle it is high; flush rides on the same cycle.

  cp0_state_e  state, state_d;
  logic [3:0]  drain_cnt, drain_cnt_d;
  logic        flush_d, redirect_valid_d;
  logic [31:0] redirect_pc_d;

  logic            status_ie, status_exl;
  logic [NIRQ-1:0] status_im, cause_ip;
  logic [31:0]     epc;

  logic       irq_pend, can_take, trap_hit, take_trap, take_eret, mtc0_we;
  logic [4:0] trap_code;

  assign irq_pend  = status_ie & ~status_exl & |(cause_ip & status_im);
  assign can_take  = (state == IDLE) & mem_valid & ~pipe_stall;
  assign trap_hit  = irq_pend | mem_unknown | mem_syscall | mem_overflow;
  assign take_trap = can_take & trap_hit;
  assign take_eret = can_take & ~trap_hit & mem_eret;
  assign exc_kill  = take_trap | take_eret;
  assign mtc0_we   = mem_cp0_we & (state == IDLE) & ~pipe_stall & ~exc_kill;
  assign dbg_state = state;

  always_comb begin
    trap_code = EXC_OV;
    if (irq_pend)         trap_code = EXC_INT;
    else if (mem_unknown) trap_code = EXC_RI;
    else if (mem_syscall) trap_code = EXC_SYS;
  end

  cp0_regs #(.NIRQ(NIRQ)) u_regs (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .trap_we    (take_trap),
    .trap_code  (trap_code),
    .trap_pc    (mem_pc),
    .eret_we    (take_eret),
    .mtc0_we    (mtc0_we),
    .dreg       (mem_cp0_dreg),
    .wdata      (mem_cp0_wdata),
    .rdata      (cp0_rdata),
    .status_ie  (status_ie),
    .status_exl (status_exl),
    .status_im  (status_im),
    .cause_ip   (cause_ip),
    .epc        (epc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      drain_cnt      <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state          <= state_d;
      drain_cnt      <= drain_cnt_d;
      flush          <= flush_d;
      redirect_valid <= redirect_valid_d;
      redirect_pc    <= redirect_pc_d;
    end
  end

  always_comb begin
    state_d          = state;
    drain_cnt_d      = drain_cnt;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = '0;
    case (state)
      IDLE: begin
        // Pulse is registered here so it is high exactly while in TRAP/RET.
        if (take_trap) begin
          state_d          = TRAP;
          flush_d          = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = HANDLER_ADDR;
        end else if (take_eret) begin
          state_d          = RET;
          flush_d          = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = epc;
        end
      end
      TRAP, RET: begin
        state_d     = DRAIN;
        drain_cnt_d = 4'(DRAIN_CYCLES - 1);
      end
      DRAIN: begin
        if (drain_cnt == 4'd0) state_d = IDLE;
        else                   drain_cnt_d = drain_cnt - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: hand-computed CP0 values, pulse timing and
// an expected-redirect queue checked whenever redirect_valid is seen.
module tb_cp0_exc_ctrl;
  import cp0_pkg::*;

  localparam int DRAIN_N = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_syscall, mem_unknown, mem_overflow, mem_eret;
  logic [31:0] mem_pc;
  logic        mem_cp0_we;
  logic [4:0]  mem_cp0_dreg;
  logic [31:0] mem_cp0_wdata;
  logic        pipe_stall;
  logic [3:0]  irq;
  logic [31:0] cp0_rdata;
  logic        exc_kill, flush, redirect_valid;
  logic [31:0] redirect_pc;
  cp0_state_e  dbg_state;

  logic [31:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  cp0_exc_ctrl #(.HANDLER_ADDR(32'h8), .DRAIN_CYCLES(DRAIN_N), .NIRQ(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_pc         (mem_pc),
    .mem_syscall    (mem_syscall),
    .mem_unknown    (mem_unknown),
    .mem_overflow   (mem_overflow),
    .mem_eret       (mem_eret),
    .mem_cp0_we     (mem_cp0_we),
    .mem_cp0_dreg   (mem_cp0_dreg),
    .mem_cp0_wdata  (mem_cp0_wdata),
    .pipe_stall     (pipe_stall),
    .irq            (irq),
    .cp0_rdata      (cp0_rdata),
    .exc_kill       (exc_kill),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every redirect pulse must match the next queued target
  always @(negedge clk) begin
    if (redirect_valid) begin
      if (exp_q.size() == 0) check("redirect_unexpected", 32'(redirect_valid), 32'd0);
      else                   check("redirect_pc", redirect_pc, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ev();
    mem_valid    = 1'b0;
    mem_syscall  = 1'b0;
    mem_unknown  = 1'b0;
    mem_overflow = 1'b0;
    mem_eret     = 1'b0;
    mem_cp0_we   = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
    mem_cp0_dreg = r;
    #1;
    check(tag, cp0_rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    mem_valid     = 1'b1;
    mem_pc        = 32'hC0;
    mem_cp0_we    = 1'b1;
    mem_cp0_dreg  = r;
    mem_cp0_wdata = d;
    tick();
    clr_ev();
  endtask

  // Event already on the inputs: expect acceptance, one pulse, DRAIN_N drain cycles.
  task automatic fire(input string tag, input logic [31:0] exp_pc, input bit drain_sys);
    #1;
    check({tag, "_kill"}, 32'(exc_kill), 32'd1);
    exp_q.push_back(exp_pc);
    tick();
    clr_ev();
    check({tag, "_flush"}, 32'(flush), 32'd1);
    check({tag, "_rv"}, 32'(redirect_valid), 32'd1);
    for (int i = 0; i < DRAIN_N; i++) begin
      tick();
      if (drain_sys) begin
        mem_valid   = 1'b1;
        mem_syscall = 1'b1;
        mem_pc      = 32'h44;
        #1;
        check({tag, "_drain_kill"}, 32'(exc_kill), 32'd0);
      end
      check({tag, "_drain_state"}, 32'(dbg_state), 32'(DRAIN));
      check({tag, "_drain_flush"}, 32'(flush), 32'd0);
    end
    clr_ev();
    tick();
    check({tag, "_idle"}, 32'(dbg_state), 32'(IDLE));
  endtask

  task automatic do_eret(input string tag, input logic [31:0] exp_pc);
    mem_valid = 1'b1;
    mem_eret  = 1'b1;
    mem_pc    = 32'hE0;
    fire(tag, exp_pc, 1'b0);
  endtask

  initial begin
    clr_ev();
    rst = 1'b1; mem_pc = '0; mem_cp0_dreg = '0; mem_cp0_wdata = '0;
    pipe_stall = 1'b0; irq = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_rv", 32'(redirect_valid), 32'd0);
    check("rst_rpc", redirect_pc, 32'd0);
    check_reg("rst_status", CP0_STATUS, 32'h0);
    check_reg("rst_cause", CP0_CAUSE, 32'h0);
    check_reg("rst_epc", CP0_EPC, 32'h0);

    // syscall, with a second syscall held during the drain window
    mem_valid = 1'b1; mem_syscall = 1'b1; mem_pc = 32'h40;
    fire("sys", 32'h8, 1'b1);
    check_reg("sys_epc", CP0_EPC, 32'h40);
    check_reg("sys_cause", CP0_CAUSE, 32'h20);
    check_reg("sys_status", CP0_STATUS, 32'h2);

    // nested unknown opcode with EXL=1 keeps EPC
    mem_valid = 1'b1; mem_unknown = 1'b1; mem_pc = 32'h80;
    fire("nest", 32'h8, 1'b0);
    check_reg("nest_epc", CP0_EPC, 32'h40);
    check_reg("nest_cause", CP0_CAUSE, 32'h28);
    do_eret("eret1", 32'h40);
    check_reg("eret1_status", CP0_STATUS, 32'h0);

    // enabled interrupt
    mtc0(CP0_STATUS, 32'h101);
    irq = 4'b0001;
    tick();
    check_reg("irq_ip", CP0_CAUSE, 32'h128);
    mem_valid = 1'b1; mem_pc = 32'h100;
    fire("irq", 32'h8, 1'b0);
    check_reg("irq_epc", CP0_EPC, 32'h100);
    check_reg("irq_cause", CP0_CAUSE, 32'h100);
    check_reg("irq_status", CP0_STATUS, 32'h103);
    irq = '0;
    tick();
    do_eret("eret2", 32'h100);
    check_reg("eret2_status", CP0_STATUS, 32'h101);

    // masked interrupt
    mtc0(CP0_STATUS, 32'h001);
    irq = 4'b0001;
    tick();
    mem_valid = 1'b1; mem_pc = 32'h200;
    #1;
    check("mask_kill", 32'(exc_kill), 32'd0);
    tick();
    clr_ev();
    check("mask_flush", 32'(flush), 32'd0);
    check_reg("mask_epc", CP0_EPC, 32'h100);
    irq = '0;
    tick();

    // priority: interrupt beats unknown and syscall
    mtc0(CP0_STATUS, 32'h101);
    irq = 4'b0001;
    tick();
    mem_valid = 1'b1; mem_unknown = 1'b1; mem_syscall = 1'b1; mem_pc = 32'h300;
    fire("prio_irq", 32'h8, 1'b0);
    check_reg("prio_irq_cause", CP0_CAUSE, 32'h100);
    check_reg("prio_irq_epc", CP0_EPC, 32'h300);
    irq = '0;
    tick();
    do_eret("eret3", 32'h300);

    // priority with irq masked: unknown beats syscall
    mtc0(CP0_STATUS, 32'h001);
    irq = 4'b0001;
    tick();
    mem_valid = 1'b1; mem_unknown = 1'b1; mem_syscall = 1'b1; mem_pc = 32'h310;
    fire("prio_ri", 32'h8, 1'b0);
    check_reg("prio_ri_cause", CP0_CAUSE, 32'h128);
    check_reg("prio_ri_epc", CP0_EPC, 32'h310);
    irq = '0;
    tick();
    do_eret("eret4", 32'h310);

    // overflow held off by stall
    mem_valid = 1'b1; mem_overflow = 1'b1; mem_pc = 32'h500; pipe_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_kill", 32'(exc_kill), 32'd0);
      tick();
      check("stall_flush", 32'(flush), 32'd0);
      check_reg("stall_epc", CP0_EPC, 32'h310);
      check_reg("stall_cause", CP0_CAUSE, 32'h28);
    end
    pipe_stall = 1'b0;
    fire("ov", 32'h8, 1'b0);
    check_reg("ov_epc", CP0_EPC, 32'h500);
    check_reg("ov_cause", CP0_CAUSE, 32'h30);
    check_reg("ov_status", CP0_STATUS, 32'h3);
    do_eret("eret5", 32'h500);

    // mtc0 / mfc0
    mtc0(CP0_EPC, 32'h1234);
    check_reg("mtc0_epc", CP0_EPC, 32'h1234);
    mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
    check_reg("mtc0_cause_ro", CP0_CAUSE, 32'h30);
    mtc0(5'd5, 32'hDEAD);
    check_reg("unmapped_rd", 5'd5, 32'h0);
    check_reg("unmapped_epc", CP0_EPC, 32'h1234);

    // mtc0 suppressed by a simultaneous trap
    mem_valid = 1'b1; mem_syscall = 1'b1; mem_pc = 32'h600;
    mem_cp0_we = 1'b1; mem_cp0_dreg = CP0_EPC; mem_cp0_wdata = 32'h7777;
    fire("sys_mtc0", 32'h8, 1'b0);
    check_reg("sys_mtc0_epc", CP0_EPC, 32'h600);

    // reset in the middle of DRAIN
    do_eret("eret6", 32'h600);
    mem_valid = 1'b1; mem_syscall = 1'b1; mem_pc = 32'h700;
    exp_q.push_back(32'h8);
    tick();
    clr_ev();
    tick();
    check("mid_state", 32'(dbg_state), 32'(DRAIN));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    check("mid_rst_flush", 32'(flush), 32'd0);
    check("mid_rst_rv", 32'(redirect_valid), 32'd0);
    check("mid_rst_rpc", redirect_pc, 32'd0);
    check_reg("mid_rst_epc", CP0_EPC, 32'h0);
    check_reg("mid_rst_status", CP0_STATUS, 32'h0);
    tick(); tick();
    check("mid_rst_quiet", 32'(redirect_valid), 32'd0);

    check("redirects_pending", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Coprocessor-0 exception and interrupt controller for the pipelined MIPS core. It owns the Status, Cause and EPC registers. It takes exception flags from the MEM stage (syscall, unknown opcode, signed overflow, eret) and external interrupt lines, and resolves them by priority. It then sequences the pipeline through a flush, a PC redirect and a fixed drain period. It also services mfc0/mtc0 accesses issued by the decoder.

## Interface
- HANDLER_ADDR, 32'h0000_0008, exception vector loaded into the PC on trap entry.
- DRAIN_CYCLES, 3, cycles of event blocking after each redirect (range 1–15).
- NIRQ, 4, number of hardware interrupt lines, mapped to Cause/Status bits [8+NIRQ-1:8].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_pc  in  32  PC of the MEM-stage instruction.
- mem_syscall, mem_unknown, mem_overflow, mem_eret  in  1 each  exception and eret flags of the MEM-stage instruction.
- mem_cp0_we  in  1  mtc0 write strobe.
- mem_cp0_dreg  in  5  CP0 register index, used for both mtc0 and mfc0.
- mem_cp0_wdata  in  32  mtc0 data.
- pipe_stall  in  1  MEM stage is not advancing this cycle.
- irq  in  NIRQ  level-sensitive interrupt requests.
- cp0_rdata  out  32  combinational read of the register selected by mem_cp0_dreg.
- exc_kill  out  1  combinational; suppresses mem write, CP0 write and WB of the MEM-stage instruction in the accepting cycle.
- flush  out  1  registered; clears IF/ID/EX/MEM.
- redirect_valid  out  1  registered; PC load strobe.
- redirect_pc  out  32  registered; PC load value.

## Operation
- **Status (reg 12):** bit0 IE, bit1 EXL, bits[11:8] IM; all other bits read 0.
- **Cause (reg 13):** bits[6:2] ExcCode, bits[11:8] IP.
  - IP is loaded from irq every cycle; there is no internal synchronizer, so irq must arrive synchronous to clk.
  - Cause is read-only to mtc0.
- **EPC (reg 14):** fully writable by mtc0.
- **Unmapped registers:** read 0; writes to them are ignored.
- **Interrupt eligibility:** IE & ~EXL & |(IP & IM). An interrupt is taken only in IDLE with mem_valid=1 and pipe_stall=0.
- **Event acceptance:** only in IDLE with mem_valid=1 and pipe_stall=0. One event is accepted per cycle, highest priority first:
  1. interrupt, ExcCode 0
  2. unknown opcode, ExcCode 10
  3. syscall, ExcCode 8
  4. overflow, ExcCode 12
  5. eret
- **Trap acceptance:**
  - ExcCode is written.
  - EPC is set to mem_pc only if EXL was 0; otherwise EPC is kept.
  - EXL is set to 1.
  - exc_kill is asserted.
  - Next state is TRAP.
- **eret acceptance:** EXL is cleared, exc_kill is asserted, next state is RET.
- **mtc0:** applied only when no event is accepted in the same cycle and the state is IDLE. A simultaneous trap suppresses the mtc0.
- **State machine:** IDLE, TRAP, RET, DRAIN.
  - TRAP → DRAIN: for one cycle, flush=1, redirect_valid=1, redirect_pc=HANDLER_ADDR.
  - RET → DRAIN: for one cycle, flush=1, redirect_valid=1, redirect_pc=EPC.
  - DRAIN: counter loaded with DRAIN_CYCLES-1 on entry and decremented each cycle. At 0, next state is IDLE. All events and mtc0 are ignored in DRAIN.

## Timing
- **Reset values:** Status=0, Cause=0, EPC=0, state IDLE, flush=0, redirect_valid=0, redirect_pc=0, drain counter 0.
  - exc_kill=0 whenever the state is not IDLE.
- **Latency:** event accepted at edge N → flush/redirect high during cycle N+1, for exactly one cycle → IDLE again DRAIN_CYCLES cycles after that.
- **CP0 update timing:** CP0 updates land at the accepting edge, so mfc0 in the following cycle sees the new values.
- **pipe_stall:** a pending exception is held by the pipeline and retried. No CP0 state changes while pipe_stall=1.
- **Reset mid-sequence:** rst in TRAP, RET or DRAIN forces IDLE and the reset values on the next edge. No redirect pulse is produced.
- **IRQ during DRAIN:** not taken; it is re-evaluated in the first IDLE cycle with a valid instruction.

## Structure
- Shared package cp0_pkg holds:
  - register indices: CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14
  - ExcCode constants: EXC_INT=0, EXC_SYS=8, EXC_RI=10, EXC_OV=12
  - state enum (IDLE, TRAP, RET, DRAIN)
  - Status/Cause bit-position constants
- One sub-module, cp0_regs: Status, Cause and EPC storage, the mtc0 write decode and the cp0_rdata mux.
- The FSM, priority encoder and drain counter live in the top level.

## Test plan
- **Syscall:** reset, mem_valid=1, mem_pc=0x40, mem_syscall=1 → exc_kill=1 that cycle; next cycle flush=1, redirect_pc=0x8; EPC=0x40, Cause[6:2]=8, EXL=1; no further redirect for 3 cycles.
- **Masked/enabled interrupt:**
  - Status=0x101 (IE, IM0), irq=4'b0001, mem_pc=0x100 → redirect to 0x8, EPC=0x100, ExcCode 0.
  - Same with IM=0 → no trap.
- **eret:** after a trap with EPC=0x40, mem_eret=1 in IDLE → redirect_pc=0x40, EXL=0; the EXL=1 nested unknown-opcode case leaves EPC unchanged.
- **Priority:** irq enabled + mem_unknown + mem_syscall in the same cycle → ExcCode 0; with the irq masked → ExcCode 10.
- **Stall/drain blocking:**
  - pipe_stall=1 with mem_overflow=1 → no change until the stall drops.
  - mem_syscall asserted during DRAIN → ignored.
- **Reset mid-DRAIN and mtc0/mfc0:**
  - rst in DRAIN → IDLE, all outputs 0.
  - mtc0 EPC=0x1234 then mfc0 reg 14 → cp0_rdata=0x1234.
  - mtc0 reg 13 → Cause unchanged.
